// File: rtl/stage2_maxpool.sv
// 2x2 stride-2 max-pooling stage for the stage-2 conv stream.
// Takes raster-order pixels with all channels packed and emits one pooled pixel per 2x2 window.
module stage2_maxpool #(
    parameter int CH   = 3,
    parameter int IBW  = 32,
    parameter int IN_X = 8,
    parameter int IN_Y = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_in_valid,
    input  logic [CH*IBW-1:0]   i_in_fmap,
    output logic                o_ot_valid,
    output logic [CH*IBW-1:0]   o_ot_fmap,
    output logic                o_ot_last
);

    localparam int W   = CH * IBW;
    localparam int CW  = (IN_X > 1) ? $clog2(IN_X) : 1;
    localparam int RW  = (IN_Y > 1) ? $clog2(IN_Y) : 1;
    localparam int LBD = IN_X / 2;
    localparam int BW  = (LBD > 1) ? $clog2(LBD) : 1;

    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [W-1:0]  hold_r;
    logic [W-1:0]  line_buf_r [LBD];

    logic [BW-1:0] idx_s;
    logic [W-1:0]  cand_s;
    logic [W-1:0]  res_s;
    logic          col_end_s;
    logic          row_end_s;

    // Per-channel unsigned maximum; result keeps the input width.
    function automatic logic [W-1:0] vmax(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] m;
        m = '0;
        for (int c = 0; c < CH; c++) begin
            m[c*IBW +: IBW] = (a[c*IBW +: IBW] > b[c*IBW +: IBW]) ? a[c*IBW +: IBW] : b[c*IBW +: IBW];
        end
        return m;
    endfunction

    assign idx_s     = BW'(col_r >> 1);
    assign col_end_s = (col_r == CW'(IN_X - 1));
    assign row_end_s = (row_r == RW'(IN_Y - 1));

    // Window merge: line buffer entry against the new beat, then against the odd-row hold value.
    always_comb begin
        cand_s = vmax(line_buf_r[idx_s], i_in_fmap);
        res_s  = vmax(hold_r, cand_s);
    end

    // Raster counters, window accumulation and the registered pooled output.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            col_r      <= '0;
            row_r      <= '0;
            hold_r     <= '0;
            o_ot_valid <= 1'b0;
            o_ot_last  <= 1'b0;
            o_ot_fmap  <= '0;
            for (int i = 0; i < LBD; i++) begin
                line_buf_r[i] <= '0;
            end
        end else begin
            o_ot_valid <= 1'b0;
            o_ot_last  <= 1'b0;
            if (i_in_valid) begin
                case ({row_r[0], col_r[0]})
                    2'b00: hold_r <= i_in_fmap;
                    2'b01: line_buf_r[idx_s] <= vmax(hold_r, i_in_fmap);
                    2'b10: hold_r <= cand_s;
                    2'b11: begin
                        o_ot_fmap  <= res_s;
                        o_ot_valid <= 1'b1;
                        o_ot_last  <= col_end_s && row_end_s;
                    end
                    default: hold_r <= hold_r;
                endcase
                if (col_end_s) begin
                    col_r <= '0;
                    row_r <= row_end_s ? RW'(0) : row_r + RW'(1);
                end else begin
                    col_r <= col_r + CW'(1);
                end
            end else begin
                col_r <= col_r;
            end
        end
    end

endmodule

// File: tb/tb_stage2_maxpool.sv
// Directed bench for stage2_maxpool: ramp, gapped, MSB-set, back-to-back and reset scenarios.
module tb_stage2_maxpool;

    localparam int CH   = 3;
    localparam int IBW  = 32;
    localparam int IN_X = 8;
    localparam int IN_Y = 8;
    localparam int W    = CH * IBW;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic [W-1:0] in_fmap;
    logic         ot_valid;
    logic [W-1:0] ot_fmap;
    logic         ot_last;

    int tests = 0;
    int fails = 0;
    int tcol, trow, last_cnt, pulse_cnt;
    logic         ev, el;
    logic [W-1:0] ef;

    always #5 clk = ~clk;

    stage2_maxpool #(.CH(CH), .IBW(IBW), .IN_X(IN_X), .IN_Y(IN_Y)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_in_valid (in_valid),
        .i_in_fmap  (in_fmap),
        .o_ot_valid (ot_valid),
        .o_ot_fmap  (ot_fmap),
        .o_ot_last  (ot_last)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Input pixel for pattern 0 = ramp, 1 = descending from 0xFFFF_FFF0, other = zeros.
    function automatic logic [W-1:0] pix(input int pat, input int r, input int c);
        logic [W-1:0] v;
        v = '0;
        for (int ch = 0; ch < CH; ch++) begin
            case (pat)
                0:       v[ch*IBW +: IBW] = 32'(r*8 + c + ch*100);
                1:       v[ch*IBW +: IBW] = 32'hFFFF_FFF0 - 32'(r*8 + c);
                default: v[ch*IBW +: IBW] = 32'd0;
            endcase
        end
        return v;
    endfunction

    // Hand-derived window maxima for the same patterns.
    function automatic logic [W-1:0] pooled(input int pat, input int pr, input int pc);
        logic [W-1:0] v;
        v = '0;
        for (int ch = 0; ch < CH; ch++) begin
            case (pat)
                0:       v[ch*IBW +: IBW] = 32'((2*pr+1)*8 + 2*pc + 1 + ch*100);
                1:       v[ch*IBW +: IBW] = 32'hFFFF_FFF0 - 32'(16*pr + 2*pc);
                default: v[ch*IBW +: IBW] = 32'd0;
            endcase
        end
        return v;
    endfunction

    // One clock: check the outcome of the previous beat, then drive the next one.
    task automatic cycle(input logic rst, input logic v, input int pat);
        @(negedge clk);
        check("valid", W'(ot_valid), W'(ev));
        check("fmap", ot_fmap, ef);
        check("last", W'(ot_last), W'(el));
        if (ot_valid) pulse_cnt++;
        if (ot_valid && ot_last) last_cnt++;
        reset_n  = rst;
        in_valid = v;
        in_fmap  = v ? pix(pat, trow, tcol) : W'($urandom);
        ev = 1'b0;
        el = 1'b0;
        if (rst) begin
            ef   = '0;
            tcol = 0;
            trow = 0;
        end else if (v) begin
            if ((trow % 2 == 1) && (tcol % 2 == 1)) begin
                ev = 1'b1;
                ef = pooled(pat, trow / 2, tcol / 2);
                el = (trow == IN_Y-1) && (tcol == IN_X-1);
            end
            if (tcol == IN_X-1) begin
                tcol = 0;
                trow = (trow == IN_Y-1) ? 0 : trow + 1;
            end else begin
                tcol++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0);
    endtask

    // gaps: 0 contiguous, 1 alternate 1/0 plus random 0-5 idle cycles.
    task automatic frame(input int pat, input int gaps, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            cycle(1'b0, 1'b1, pat);
            if (gaps == 1) begin
                if (b % 2 == 1) idle(1);
                else idle($urandom_range(0, 5));
            end
        end
    endtask

    initial begin
        reset_n  = 1'b1;
        in_valid = 1'b0;
        in_fmap  = '0;
        repeat (2) @(posedge clk);
        ev = 1'b0; el = 1'b0; ef = '0; tcol = 0; trow = 0;
        last_cnt = 0; pulse_cnt = 0;
        cycle(1'b1, 1'b0, 0);

        // 1: contiguous ramp
        frame(0, 0, 64);
        idle(3);
        check("t1_pulses", W'(pulse_cnt), W'(16));
        check("t1_lasts", W'(last_cnt), W'(1));

        // 2: gapped ramp
        pulse_cnt = 0;
        frame(0, 1, 64);
        idle(3);
        check("t2_pulses", W'(pulse_cnt), W'(16));

        // 3: MSB-set values, max at top-left
        frame(1, 0, 64);
        idle(2);

        // 4: back-to-back ramp then zeros
        last_cnt = 0;
        pulse_cnt = 0;
        frame(0, 0, 64);
        frame(2, 0, 64);
        idle(3);
        check("t4_lasts", W'(last_cnt), W'(2));
        check("t4_pulses", W'(pulse_cnt), W'(32));

        // 5: reset after 37 beats, then full frame
        frame(0, 0, 37);
        cycle(1'b1, 1'b0, 0);
        idle(2);
        pulse_cnt = 0;
        frame(0, 0, 64);
        idle(2);
        check("t5_pulses", W'(pulse_cnt), W'(16));

        // 6: reset on an odd/odd beat, then full frame
        frame(0, 0, 9);
        cycle(1'b1, 1'b1, 0);
        idle(2);
        pulse_cnt = 0;
        last_cnt = 0;
        frame(0, 0, 64);
        idle(2);
        check("t6_pulses", W'(pulse_cnt), W'(16));
        check("t6_lasts", W'(last_cnt), W'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
